// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the mips32 run controller: FSM state encoding,
// host command opcodes and the core's halt opcode.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CRST = 3'd2,
        ST_RUN  = 3'd3,
        ST_STEP = 3'd4
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    // Opcode the core decodes as halt; kept here so core and harness agree.
    localparam logic [5:0] HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Bundle of all non-clock signals around the run controller: host command
// and load ports, instruction-memory write port, core control and status.
// master = host/harness/core side, slave = the run controller itself.
interface mips_run_ctrl_if #(
    parameter int AW = 10,
    parameter int CW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          core_en;
    logic          core_hlt;
    logic [2:0]    state;
    logic          done;
    logic          err;
    logic          timeout;
    logic [CW-1:0] cyc_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, ld_valid, ld_data, core_hlt,
        input  cmd_ready, ld_ready, imem_we, imem_addr, imem_wdata,
               core_rst, core_en, state, done, err, timeout, cyc_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, ld_valid, ld_data, core_hlt,
        output cmd_ready, ld_ready, imem_we, imem_addr, imem_wdata,
               core_rst, core_en, state, done, err, timeout, cyc_cnt
    );
endinterface

// File: rtl/sat_cycle_counter.sv
// Saturating core-cycle counter with synchronous clear, plus the watchdog
// compare. limit_hit fires in the cycle whose increment lands on RUN_LIMIT,
// so the FSM can stop the core on the same edge the count reaches the limit.
module sat_cycle_counter #(
    parameter int CW        = 32,
    parameter int RUN_LIMIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          limit_hit
);

    // Count enabled core cycles, clear on a new run, hold at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (RUN_LIMIT == 0) begin : g_no_limit
            assign limit_hit = 1'b0;
        end else begin : g_limit
            localparam logic [CW-1:0] LAST = CW'(RUN_LIMIT - 1);
            assign limit_hit = en && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle mips32 core. Streams instruction
// words into imem in code mode, and in execute mode pulses the core reset,
// then enables the core until it halts, the watchdog fires or the host aborts.
// Every output is a flop; nothing passes combinationally from input to output.
module mips_run_ctrl #(
    parameter int AW        = 10,
    parameter int CW        = 32,
    parameter int RUN_LIMIT = 0
) (
    input logic           clk,
    input logic           rst,
    mips_run_ctrl_if.slave bus
);
    import mips_ctrl_pkg::*;

    state_t        state_q;
    logic          cmd_ready_q;
    logic          ld_ready_q;
    logic          imem_we_q;
    logic [AW-1:0] imem_addr_q;
    logic [31:0]   imem_wdata_q;
    logic          core_rst_q;
    logic          core_en_q;
    logic          done_q;
    logic          err_q;
    logic          timeout_q;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   remain_q;

    logic [CW-1:0] cyc_cnt;
    logic          limit_hit;
    logic          cmd_fire;
    logic          ld_fire;
    logic          is_abort;
    logic          last_beat;
    logic          cnt_clr;

    assign cmd_fire  = bus.cmd_valid & cmd_ready_q;
    assign ld_fire   = bus.ld_valid & ld_ready_q;
    assign is_abort  = (bus.cmd_op == OP_ABORT);
    assign last_beat = (remain_q == {{AW{1'b0}}, 1'b1});
    assign cnt_clr   = (state_q == ST_IDLE) && cmd_fire && (bus.cmd_op == OP_RUN);

    sat_cycle_counter #(
        .CW        (CW),
        .RUN_LIMIT (RUN_LIMIT)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .en        (core_en_q),
        .cnt       (cyc_cnt),
        .limit_hit (limit_hit)
    );

    // Mode sequencer; all outputs are set on the transition into each state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b1;
            ld_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            core_en_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            ptr_q        <= '0;
            remain_q     <= '0;
        end else begin
            imem_we_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (bus.cmd_op == OP_LOAD) begin
                            if (bus.cmd_len == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                ptr_q      <= bus.cmd_addr;
                                remain_q   <= bus.cmd_len;
                                ld_ready_q <= 1'b1;
                                state_q    <= ST_LOAD;
                            end
                        end else if (bus.cmd_op == OP_RUN) begin
                            timeout_q   <= 1'b0;
                            core_rst_q  <= 1'b1;
                            cmd_ready_q <= 1'b0;
                            state_q     <= ST_CRST;
                        end else if (bus.cmd_op == OP_STEP) begin
                            core_en_q   <= 1'b1;
                            cmd_ready_q <= 1'b0;
                            state_q     <= ST_STEP;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (ld_fire) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= ptr_q;
                        imem_wdata_q <= bus.ld_data;
                        ptr_q        <= ptr_q + 1'b1;
                        remain_q     <= remain_q - 1'b1;
                    end
                    if (cmd_fire && !is_abort) begin
                        err_q <= 1'b1;
                    end
                    if ((cmd_fire && is_abort) || (ld_fire && last_beat)) begin
                        ld_ready_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_CRST: begin
                    core_rst_q  <= 1'b0;
                    core_en_q   <= 1'b1;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_RUN;
                end
                ST_RUN: begin
                    if (cmd_fire && !is_abort) begin
                        err_q <= 1'b1;
                    end
                    if (bus.core_hlt || limit_hit || (cmd_fire && is_abort)) begin
                        core_en_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_IDLE;
                        if (!bus.core_hlt && limit_hit) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    core_en_q   <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    done_q      <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    core_en_q   <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    ld_ready_q  <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.ld_ready   = ld_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.core_en    = core_en_q;
    assign bus.state      = state_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.timeout    = timeout_q;
    assign bus.cyc_cnt    = cyc_cnt;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: a per-cycle vector table for the
// load/run/step/abort flows, then hand sequences for watchdog expiry,
// halt-beats-watchdog and asynchronous reset mid-run.
module tb_mips_run_ctrl;
    import mips_ctrl_pkg::*;

    localparam int AW        = 10;
    localparam int CW        = 32;
    localparam int RUN_LIMIT = 8;

    typedef struct packed {
        logic [2:0]  st;
        logic        crdy;
        logic        lrdy;
        logic        we;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        logic        crst;
        logic        cen;
        logic        dn;
        logic        er;
        logic        to;
        logic [31:0] cnt;
    } out_t;

    typedef struct {
        logic        cv;
        logic [1:0]  op;
        logic [9:0]  addr;
        logic [10:0] len;
        logic        lv;
        logic [31:0] data;
        logic        hlt;
        out_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mips_run_ctrl_if #(.AW(AW), .CW(CW)) bus ();

    mips_run_ctrl #(.AW(AW), .CW(CW), .RUN_LIMIT(RUN_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic out_t o(logic [2:0] st, logic crdy, logic lrdy, logic we,
                               logic [9:0] waddr, logic [31:0] wdata, logic crst,
                               logic cen, logic dn, logic er, logic to, logic [31:0] cnt);
        out_t r;
        r.st = st; r.crdy = crdy; r.lrdy = lrdy; r.we = we;
        r.waddr = waddr; r.wdata = wdata; r.crst = crst; r.cen = cen;
        r.dn = dn; r.er = er; r.to = to; r.cnt = cnt;
        return r;
    endfunction

    function automatic vec_t mk(logic cv, logic [1:0] op, logic [9:0] addr, logic [10:0] len,
                                logic lv, logic [31:0] data, logic hlt, out_t exp);
        vec_t v;
        v.cv = cv; v.op = op; v.addr = addr; v.len = len;
        v.lv = lv; v.data = data; v.hlt = hlt; v.exp = exp;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.cmd_valid = v.cv;
        bus.cmd_op    = v.op;
        bus.cmd_addr  = v.addr;
        bus.cmd_len   = v.len;
        bus.ld_valid  = v.lv;
        bus.ld_data   = v.data;
        bus.core_hlt  = v.hlt;
    endtask

    task automatic setIdle();
        applyStimulus(mk(0, 2'b00, 10'd0, 11'd0, 0, 32'h0, 0, o(0,0,0,0,0,0,0,0,0,0,0,0)));
    endtask

    // Whole-output comparison; write address/data only matter when a write is expected.
    task automatic checkOutput(input string name, input out_t exp, input bit full);
        out_t act;
        act.st = bus.state; act.crdy = bus.cmd_ready; act.lrdy = bus.ld_ready;
        act.we = bus.imem_we; act.waddr = bus.imem_addr; act.wdata = bus.imem_wdata;
        act.crst = bus.core_rst; act.cen = bus.core_en; act.dn = bus.done;
        act.er = bus.err; act.to = bus.timeout; act.cnt = bus.cyc_cnt;
        if (!full && !exp.we) begin
            act.waddr = '0; act.wdata = '0;
            exp.waddr = '0; exp.wdata = '0;
        end
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got st=%0d crdy=%b lrdy=%b we=%b a=%0d d=%h crst=%b en=%b done=%b err=%b to=%b cnt=%0d | want st=%0d crdy=%b lrdy=%b we=%b a=%0d d=%h crst=%b en=%b done=%b err=%b to=%b cnt=%0d",
                     name, act.st, act.crdy, act.lrdy, act.we, act.waddr, act.wdata, act.crst,
                     act.cen, act.dn, act.er, act.to, act.cnt,
                     exp.st, exp.crdy, exp.lrdy, exp.we, exp.waddr, exp.wdata, exp.crst,
                     exp.cen, exp.dn, exp.er, exp.to, exp.cnt);
        end
    endtask

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Hard stop in case something upstream hangs.
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int en_cycles;
        bit got_done;

        setIdle();

        // Per-cycle vectors: inputs held for one cycle, outputs expected after its edge.
        // LOAD addr=0 len=3 with ld_valid gaps
        vecs.push_back(mk(1, OP_LOAD, 10'd0, 11'd3, 0, 32'h0, 0, o(1,1,1,0,0,0,1,0,0,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 1, 32'h00010001, 0, o(1,1,1,1,0,32'h00010001,1,0,0,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 0, o(1,1,1,0,0,0,1,0,0,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 1, 32'h00020002, 0, o(1,1,1,1,1,32'h00020002,1,0,0,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 0, o(1,1,1,0,0,0,1,0,0,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 1, 32'h00030003, 0, o(0,1,0,1,2,32'h00030003,1,0,1,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 0, o(0,1,0,0,0,0,1,0,0,0,0,0)));
        // LOAD addr=1022 len=4 wraps; RUN mid-load is dropped with err
        vecs.push_back(mk(1, OP_LOAD, 10'd1022, 11'd4, 0, 32'h0, 0, o(1,1,1,0,0,0,1,0,0,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 1, 32'hA0000001, 0, o(1,1,1,1,1022,32'hA0000001,1,0,0,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 1, 32'hA0000002, 0, o(1,1,1,1,1023,32'hA0000002,1,0,0,0,0,0)));
        vecs.push_back(mk(1, OP_RUN, 10'd0, 11'd0, 1, 32'hA0000003, 0, o(1,1,1,1,0,32'hA0000003,1,0,0,1,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 1, 32'hA0000004, 0, o(0,1,0,1,1,32'hA0000004,1,0,1,0,0,0)));
        // ABORT together with a beat: beat still written
        vecs.push_back(mk(1, OP_LOAD, 10'd5, 11'd3, 0, 32'h0, 0, o(1,1,1,0,0,0,1,0,0,0,0,0)));
        vecs.push_back(mk(1, OP_ABORT, 10'd0, 11'd0, 1, 32'hB0000005, 0, o(0,1,0,1,5,32'hB0000005,1,0,1,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 1, 32'hC0000000, 0, o(0,1,0,0,0,0,1,0,0,0,0,0)));
        // zero-length LOAD and idle ABORT: done only
        vecs.push_back(mk(1, OP_LOAD, 10'd7, 11'd0, 0, 32'h0, 0, o(0,1,0,0,0,0,1,0,1,0,0,0)));
        vecs.push_back(mk(1, OP_ABORT, 10'd0, 11'd0, 0, 32'h0, 0, o(0,1,0,0,0,0,1,0,1,0,0,0)));
        // RUN, halt on 5th enabled cycle
        vecs.push_back(mk(1, OP_RUN, 10'd0, 11'd0, 0, 32'h0, 0, o(2,0,0,0,0,0,1,0,0,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 0, o(3,1,0,0,0,0,0,1,0,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 0, o(3,1,0,0,0,0,0,1,0,0,0,1)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 0, o(3,1,0,0,0,0,0,1,0,0,0,2)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 0, o(3,1,0,0,0,0,0,1,0,0,0,3)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 0, o(3,1,0,0,0,0,0,1,0,0,0,4)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 1, o(0,1,0,0,0,0,0,0,1,0,0,5)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 0, o(0,1,0,0,0,0,0,0,0,0,0,5)));
        // STEP keeps core_rst low and adds one cycle
        vecs.push_back(mk(1, OP_STEP, 10'd0, 11'd0, 0, 32'h0, 0, o(4,0,0,0,0,0,0,1,0,0,0,5)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 0, o(0,1,0,0,0,0,0,0,1,0,0,6)));
        // halt beats ABORT in the same cycle
        vecs.push_back(mk(1, OP_RUN, 10'd0, 11'd0, 0, 32'h0, 0, o(2,0,0,0,0,0,1,0,0,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 0, o(3,1,0,0,0,0,0,1,0,0,0,0)));
        vecs.push_back(mk(1, OP_ABORT, 10'd0, 11'd0, 0, 32'h0, 1, o(0,1,0,0,0,0,0,0,1,0,0,1)));
        // STEP during RUN is an error; ABORT ends the run
        vecs.push_back(mk(1, OP_RUN, 10'd0, 11'd0, 0, 32'h0, 0, o(2,0,0,0,0,0,1,0,0,0,0,0)));
        vecs.push_back(mk(0, OP_LOAD, 10'd0, 11'd0, 0, 32'h0, 0, o(3,1,0,0,0,0,0,1,0,0,0,0)));
        vecs.push_back(mk(1, OP_STEP, 10'd0, 11'd0, 0, 32'h0, 0, o(3,1,0,0,0,0,0,1,0,1,0,1)));
        vecs.push_back(mk(1, OP_ABORT, 10'd0, 11'd0, 0, 32'h0, 0, o(0,1,0,0,0,0,0,0,1,0,0,2)));

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset", o(0,1,0,0,0,0,1,0,0,0,0,0), 1'b1);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
        end
        @(negedge clk);
        setIdle();

        // Watchdog expiry: 8 enabled cycles, then timeout and done
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_RUN;
        @(negedge clk);
        setIdle();
        en_cycles = 0;
        got_done = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            @(negedge clk);
            if (bus.core_en) en_cycles++;
            if (bus.done) got_done = 1'b1;
        end
        checkValue("wd_done_seen", 64'(got_done), 64'd1);
        checkValue("wd_en_cycles", 64'(en_cycles), 64'd8);
        checkValue("wd_cyc_cnt", 64'(bus.cyc_cnt), 64'd8);
        checkValue("wd_timeout", 64'(bus.timeout), 64'd1);
        checkValue("wd_core_en", 64'(bus.core_en), 64'd0);
        checkValue("wd_state", 64'(bus.state), 64'd0);
        @(negedge clk);
        checkValue("wd_timeout_sticky", 64'(bus.timeout), 64'd1);
        checkValue("wd_done_pulse", 64'(bus.done), 64'd0);

        // Next RUN clears timeout; halt on the 8th cycle beats the watchdog
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_RUN;
        @(negedge clk);
        setIdle();
        checkValue("run2_state_crst", 64'(bus.state), 64'd2);
        checkValue("run2_timeout_clr", 64'(bus.timeout), 64'd0);
        checkValue("run2_core_rst", 64'(bus.core_rst), 64'd1);
        en_cycles = 0;
        for (int i = 0; i < 40 && en_cycles < 8; i++) begin
            @(negedge clk);
            if (bus.core_en) en_cycles++;
        end
        checkValue("hw_en_cycles", 64'(en_cycles), 64'd8);
        bus.core_hlt = 1'b1;
        @(posedge clk);
        #1;
        bus.core_hlt = 1'b0;
        checkValue("hw_done", 64'(bus.done), 64'd1);
        checkValue("hw_timeout", 64'(bus.timeout), 64'd0);
        checkValue("hw_cyc_cnt", 64'(bus.cyc_cnt), 64'd8);
        checkValue("hw_state", 64'(bus.state), 64'd0);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_RUN;
        @(negedge clk);
        setIdle();
        repeat (3) @(negedge clk);
        checkValue("ar_pre_core_en", 64'(bus.core_en), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("ar_async", o(0,1,0,0,0,0,1,0,0,0,0,0), 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ar_after", o(0,1,0,0,0,0,1,0,0,0,0,0), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
